// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared types and constants for the AXI4-Lite adder scheduler
package adder_sched_pkg;

    // Job sequencer states; every job walks IDLE -> WR_A -> WR_B -> RD_SUM -> RESP.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_A   = 3'd1,
        ST_WR_B   = 3'd2,
        ST_RD_SUM = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Adder slave register map, relative to the slave base address.
    localparam logic [31:0] OFF_A   = 32'h0;
    localparam logic [31:0] OFF_B   = 32'h4;
    localparam logic [31:0] OFF_SUM = 32'h8;

    localparam logic [1:0] AXI_OKAY = 2'b00;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with rotating priority pointer
//
// Ports:
//   clk_i        clock, rising edge
//   resetn_i     synchronous active-low reset; pointer returns to requester 0
//   req_i        one request bit per requester
//   advance_i    a grant was taken this cycle; pointer moves past the winner
//   grant_o      one-hot grant (zero when no request)
//   grant_idx_o  binary index of the granted requester
//   any_o        at least one request is pending
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            advance_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   grant_idx_o,
    output logic            any_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] sel;
    logic          found;
    int            pos;
    int            nxt;

    // Scan starting at the pointer, wrapping, and take the first pending request.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!found && req_i[pos]) begin
                found = 1'b1;
                sel   = IW'(pos);
            end
        end
    end

    assign grant_o     = found ? (NREQ'(1) << sel) : '0;
    assign grant_idx_o = sel;
    assign any_o       = found;

    // The requester just served drops to lowest priority.
    always_comb begin
        ptr_d = ptr_q;
        nxt   = int'(sel) + 1;
        if (advance_i) begin
            ptr_d = (nxt >= NREQ) ? '0 : IW'(nxt);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adder_axil_sched.sv
// rtl/adder_axil_sched.sv - shares one AXI4-Lite adder slave among NREQ requesters
//
// Ports:
//   ACLK, ARESETN          clock (rising edge) and synchronous active-low reset
//   req_valid/req_ready    per-requester handshake; req_ready is a one-cycle one-hot grant
//   req_a, req_b           operand pairs, requester i at [32*i +: 32]
//   rsp_valid              one-cycle one-hot result pulse to the granted requester
//   rsp_data, rsp_err      sum read back and sticky response-error flag of the job
//   m_aw*, m_w*, m_b*      AXI4-Lite write channels toward the adder slave
//   m_ar*, m_r*            AXI4-Lite read channels toward the adder slave
module adder_axil_sched
    import adder_sched_pkg::*;
#(
    parameter int          NREQ      = 2,
    parameter int          ADDR_W    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [2:0]        m_awprot,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [ADDR_W-1:0] ADDR_A   = ADDR_W'(BASE_ADDR + OFF_A);
    localparam logic [ADDR_W-1:0] ADDR_B   = ADDR_W'(BASE_ADDR + OFF_B);
    localparam logic [ADDR_W-1:0] ADDR_SUM = ADDR_W'(BASE_ADDR + OFF_SUM);

    state_t        state_q,    state_d;
    logic [31:0]   a_q,        a_d;
    logic [31:0]   b_q,        b_d;
    logic [IW-1:0] gidx_q,     gidx_d;
    logic          err_q,      err_d;
    logic          aw_done_q,  aw_done_d;
    logic          w_done_q,   w_done_d;
    logic          ar_done_q,  ar_done_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q,  rsp_err_d;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            any_req;
    logic            accept;
    logic            aw_hs;
    logic            w_hs;
    logic            b_hs;
    logic            ar_hs;
    logic            r_hs;

    // Gated by ARESETN so no grant is advertised while reset is held.
    assign accept = (state_q == ST_IDLE) && ARESETN && any_req;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk_i       (ACLK),
        .resetn_i    (ARESETN),
        .req_i       (req_valid),
        .advance_i   (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (any_req)
    );

    assign m_awprot = 3'b000;
    assign m_arprot = 3'b000;
    assign m_wstrb  = 4'hF;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        gidx_d     = gidx_q;
        err_d      = err_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        ar_done_d  = ar_done_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        req_ready  = '0;
        rsp_valid  = '0;
        m_awaddr   = '0;
        m_awvalid  = 1'b0;
        m_wdata    = '0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        m_araddr   = '0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;

        aw_hs = 1'b0;
        w_hs  = 1'b0;
        b_hs  = 1'b0;
        ar_hs = 1'b0;
        r_hs  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready = grant;
                    a_d       = req_a[32*grant_idx +: 32];
                    b_d       = req_b[32*grant_idx +: 32];
                    gidx_d    = grant_idx;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_A;
                end
            end

            ST_WR_A, ST_WR_B: begin
                // AW and W are independent; each valid drops after its own handshake.
                m_awaddr  = (state_q == ST_WR_A) ? ADDR_A : ADDR_B;
                m_wdata   = (state_q == ST_WR_A) ? a_q : b_q;
                m_awvalid = !aw_done_q;
                m_wvalid  = !w_done_q;
                aw_hs     = !aw_done_q && m_awready;
                w_hs      = !w_done_q && m_wready;
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                end
                m_bready = aw_done_q && w_done_q;
                b_hs     = aw_done_q && w_done_q && m_bvalid;
                if (b_hs) begin
                    // A slave error is recorded but the job carries on.
                    err_d     = err_q | (m_bresp != AXI_OKAY);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    ar_done_d = 1'b0;
                    state_d   = (state_q == ST_WR_A) ? ST_WR_B : ST_RD_SUM;
                end
            end

            ST_RD_SUM: begin
                m_araddr  = ADDR_SUM;
                m_arvalid = !ar_done_q;
                ar_hs     = !ar_done_q && m_arready;
                if (ar_hs) begin
                    ar_done_d = 1'b1;
                end
                m_rready = ar_done_q;
                r_hs     = ar_done_q && m_rvalid;
                if (r_hs) begin
                    rsp_data_d = m_rdata;
                    rsp_err_d  = err_q | (m_rresp != AXI_OKAY);
                    state_d    = ST_RESP;
                end
            end

            ST_RESP: begin
                rsp_valid = NREQ'(1) << gidx_q;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            gidx_q     <= '0;
            err_q      <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            ar_done_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            gidx_q     <= gidx_d;
            err_q      <= err_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            ar_done_q  <= ar_done_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_adder_axil_sched.sv
// tb/tb_adder_axil_sched.sv - scoreboard bench for adder_axil_sched with AXI4-Lite adder slave model
module tb_adder_axil_sched;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 4;

    logic                ACLK = 1'b0;
    logic                ARESETN;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_a;
    logic [NREQ*32-1:0]  req_b;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_data;
    logic                rsp_err;
    logic [ADDR_W-1:0]   m_awaddr;
    logic [2:0]          m_awprot;
    logic                m_awvalid;
    logic                m_awready;
    logic [31:0]         m_wdata;
    logic [3:0]          m_wstrb;
    logic                m_wvalid;
    logic                m_wready;
    logic [1:0]          m_bresp;
    logic                m_bvalid;
    logic                m_bready;
    logic [ADDR_W-1:0]   m_araddr;
    logic [2:0]          m_arprot;
    logic                m_arvalid;
    logic                m_arready;
    logic [31:0]         m_rdata;
    logic [1:0]          m_rresp;
    logic                m_rvalid;
    logic                m_rready;

    always #5 ACLK = ~ACLK;

    adder_axil_sched #(
        .NREQ      (NREQ),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (32'h0)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .m_awaddr  (m_awaddr),
        .m_awprot  (m_awprot),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_araddr  (m_araddr),
        .m_arprot  (m_arprot),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge ACLK) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [31:0] sum;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } ops_t;

    exp_t        sb[$];
    ops_t        pend_q0[$];
    ops_t        pend_q1[$];
    logic [31:0] a_drv [NREQ];
    logic [31:0] b_drv [NREQ];
    int          rr_model;
    int          grant_cycle;
    bit          check_lat;
    int          aw_base, w_base, ar_base;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
        assign req_a[32*gi +: 32] = a_drv[gi];
        assign req_b[32*gi +: 32] = b_drv[gi];
    end

    // Slave model: register file at 0x0/0x4, sum of the two at 0x8.
    int          slave_mode;   // 0 random, 1 zero-wait, 2 AW 3 cycles after W, 3 W 3 cycles after AW
    bit          berr_b;       // SLVERR on writes to 0x4
    logic [31:0] regs [2];
    bit          have_aw, have_w, b_pend, ar_got;
    logic [ADDR_W-1:0] aw_addr_l, ar_addr_l;
    logic [31:0] w_data_l;
    logic [1:0]  b_resp_l;
    int          b_wait, r_wait, skew_aw, skew_w;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;

    initial begin
        bit rst, aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic [ADDR_W-1:0] s_awaddr, s_araddr;
        logic [31:0] s_wdata;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        have_aw = 0; have_w = 0; b_pend = 0; ar_got = 0;
        skew_aw = 0; skew_w = 0; b_wait = 0; r_wait = 0;
        regs[0] = 0; regs[1] = 0;
        forever begin
            @(negedge ACLK);
            rst      = !ARESETN;
            aw_hs    = m_awvalid && m_awready;
            w_hs     = m_wvalid && m_wready;
            b_hs     = m_bvalid && m_bready;
            ar_hs    = m_arvalid && m_arready;
            r_hs     = m_rvalid && m_rready;
            s_awaddr = m_awaddr;
            s_araddr = m_araddr;
            s_wdata  = m_wdata;
            @(posedge ACLK);
            #1;
            if (rst) begin
                have_aw = 0; have_w = 0; b_pend = 0; ar_got = 0;
                skew_aw = 0; skew_w = 0;
                m_bvalid = 0; m_rvalid = 0;
                m_awready = 0; m_wready = 0; m_arready = 0;
            end else begin
                if (aw_hs) begin have_aw = 1; aw_addr_l = s_awaddr; aw_cnt++; skew_aw = 0; end
                else if (skew_aw > 0) skew_aw++;
                if (w_hs) begin have_w = 1; w_data_l = s_wdata; w_cnt++; skew_w = 0; end
                else if (skew_w > 0) skew_w++;
                if (slave_mode == 2 && w_hs) skew_aw = 1;
                if (slave_mode == 3 && aw_hs) skew_w = 1;
                if (b_hs) m_bvalid = 0;
                if (r_hs) m_rvalid = 0;
                if (ar_hs) begin
                    ar_got = 1; ar_addr_l = s_araddr; ar_cnt++;
                    r_wait = (slave_mode == 1) ? 0 : $urandom_range(0, 3);
                end
                if (have_aw && have_w && !b_pend && !m_bvalid) begin
                    if (aw_addr_l == 4'h0) regs[0] = w_data_l;
                    if (aw_addr_l == 4'h4) regs[1] = w_data_l;
                    b_resp_l = (berr_b && aw_addr_l == 4'h4) ? 2'b10 : 2'b00;
                    have_aw = 0; have_w = 0; b_pend = 1;
                    b_wait = (slave_mode == 1) ? 0 : $urandom_range(0, 3);
                end
                if (b_pend) begin
                    if (b_wait == 0) begin m_bvalid = 1; m_bresp = b_resp_l; b_pend = 0; end
                    else b_wait--;
                end
                if (ar_got && !m_rvalid) begin
                    if (r_wait == 0) begin
                        m_rvalid = 1; m_rresp = 2'b00; ar_got = 0;
                        m_rdata  = (ar_addr_l == 4'h8) ? regs[0] + regs[1] : 32'hDEAD_BEEF;
                    end else r_wait--;
                end
                case (slave_mode)
                    1: begin m_awready = 1; m_wready = 1; m_arready = 1; end
                    2: begin m_wready = 1; m_awready = (skew_aw >= 3); m_arready = 1; end
                    3: begin m_awready = 1; m_wready = (skew_w >= 3); m_arready = 1; end
                    default: begin
                        m_awready = 1'($urandom_range(0, 1));
                        m_wready  = 1'($urandom_range(0, 1));
                        m_arready = 1'($urandom_range(0, 1));
                    end
                endcase
            end
        end
    end

    // Requesters: hold valid while operands are queued, observe grants, push expectations.
    initial begin
        logic [NREQ-1:0] gnt;
        int g, eg, pos;
        bit taken;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin a_drv[i] = 0; b_drv[i] = 0; end
        rr_model = 0;
        forever begin
            @(negedge ACLK);
            gnt   = req_ready;
            taken = 0;
            g     = 0;
            if (gnt != '0) begin
                taken = 1;
                for (int i = NREQ - 1; i >= 0; i--) if (gnt[i]) g = i;
                check("ready_onehot", 32'($countones(gnt)), 32'd1);
                eg = -1;
                for (int k = 0; k < NREQ; k++) begin
                    pos = (rr_model + k) % NREQ;
                    if (eg < 0 && req_valid[pos]) eg = pos;
                end
                check("grant_idx", 32'(g), 32'(eg));
                rr_model = (eg + 1) % NREQ;
                sb.push_back('{idx: g, sum: a_drv[g] + b_drv[g], err: berr_b});
                grant_cycle = cyc;
                aw_base = aw_cnt; w_base = w_cnt; ar_base = ar_cnt;
            end
            @(posedge ACLK);
            #1;
            if (taken) begin
                req_valid[g] = 1'b0;
                if (g == 0) void'(pend_q0.pop_front());
                else        void'(pend_q1.pop_front());
            end
            if (!req_valid[0] && pend_q0.size() > 0) begin
                a_drv[0] = pend_q0[0].a; b_drv[0] = pend_q0[0].b; req_valid[0] = 1'b1;
            end
            if (!req_valid[1] && pend_q1.size() > 0) begin
                a_drv[1] = pend_q1[0].a; b_drv[1] = pend_q1[0].b; req_valid[1] = 1'b1;
            end
        end
    end

    // Monitor: every response is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(1 << e.idx));
                    check("rsp_data", rsp_data, e.sum);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("aw_handshakes", 32'(aw_cnt - aw_base), 32'd2);
                    check("w_handshakes", 32'(w_cnt - w_base), 32'd2);
                    check("ar_handshakes", 32'(ar_cnt - ar_base), 32'd1);
                    if (check_lat) check("latency", 32'(cyc - grant_cycle), 32'd7);
                end
            end
        end
    end

    task automatic push_job(input int r, input logic [31:0] a, input logic [31:0] b);
        if (r == 0) pend_q0.push_back('{a: a, b: b});
        else        pend_q1.push_back('{a: a, b: b});
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((pend_q0.size() > 0 || pend_q1.size() > 0 || req_valid != '0 || sb.size() > 0)
               && n < budget) begin
            @(posedge ACLK);
            n++;
        end
        repeat (2) @(posedge ACLK);
        check({name, "_timeout"}, 32'(n >= budget), 32'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_req_ready"}, 32'(req_ready), 32'd0);
        check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, "_rsp_data"}, rsp_data, 32'd0);
        check({name, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({name, "_axi_valids"}, 32'({m_awvalid, m_wvalid, m_arvalid}), 32'd0);
        check({name, "_axi_readies"}, 32'({m_bready, m_rready}), 32'd0);
    endtask

    initial begin
        int n;
        ARESETN    = 1'b0;
        slave_mode = 1;
        berr_b     = 0;
        check_lat  = 0;
        repeat (3) @(posedge ACLK);
        #1;
        check_idle_outputs("reset");
        check("wstrb", 32'(m_wstrb), 32'hF);
        check("prot", 32'({m_awprot, m_arprot}), 32'd0);
        ARESETN = 1'b1;

        // Basic job with a zero-wait slave, including minimum latency.
        check_lat = 1;
        push_job(0, 32'd1, 32'd2);
        wait_done("basic", 200);
        check_lat = 0;

        // 32-bit wrap of the slave's sum.
        push_job(0, 32'hFFFF_FFFF, 32'd1);
        wait_done("wrap", 200);

        // SLVERR on the B write marks the job; the following job is clean.
        berr_b = 1;
        push_job(1, 32'd10, 32'd20);
        wait_done("berr", 300);
        berr_b = 0;
        push_job(1, 32'd5, 32'd6);
        wait_done("after_err", 300);

        // AW accepted late after W, then the reverse.
        slave_mode = 2;
        push_job(0, $urandom, $urandom);
        wait_done("aw_late", 300);
        slave_mode = 3;
        push_job(1, $urandom, $urandom);
        wait_done("w_late", 300);

        // Both requesters held busy with random slave stalls.
        slave_mode = 0;
        for (int i = 0; i < 6; i++) begin
            push_job(0, $urandom, $urandom);
            push_job(1, $urandom, $urandom);
        end
        wait_done("contend", 5000);

        // Reset while the sum read is in progress.
        slave_mode = 1;
        push_job(1, 32'd7, 32'd8);
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!(m_arvalid || m_rready) && n < 200);
        check("rd_sum_reached", 32'(n >= 200), 32'd0);
        ARESETN = 1'b0;
        @(posedge ACLK);
        #1;
        check_idle_outputs("mid_reset");
        sb.delete();
        rr_model = 0;
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        push_job(0, 32'h1234_5678, 32'h1111_1111);
        wait_done("post_reset", 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
